// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD   = 4'd3;
    localparam logic [3:0] ST_MEM_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_R_EXEC   = 4'd6;
    localparam logic [3:0] ST_R_WB     = 4'd7;
    localparam logic [3:0] ST_I_EXEC   = 4'd8;
    localparam logic [3:0] ST_I_WB     = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;
    localparam logic [3:0] ST_TRAP     = 4'd12;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRC_B_RT   = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;
    localparam logic [1:0] SRC_B_BR   = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences the shared ALU/memory/IR datapath,
// counts retired instructions and traps on illegal opcodes.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          op_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    output logic                pc_en_o,
    output logic                iord_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic                mem_to_reg_o,
    output logic                reg_dst_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [1:0]          alu_op_o,
    output logic [1:0]          pc_source_o,
    output logic                trap_o,
    output logic [RETIRE_W-1:0] retired_o
);

    logic [3:0]          state_reg;
    logic [3:0]          state_next;
    logic [RETIRE_W-1:0] retired_reg;
    logic                trap_reg;
    logic                retire;
    ctrl_t               ctrl;
    ctrl_t               ctrl_gated;

    always_comb begin
        state_next = state_reg;
        ctrl       = '0;
        retire     = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                if (mem_ready_i) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_en    = 1'b1;
                    state_next    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ctrl.alu_src_b = SRC_B_BR;
                ctrl.alu_op    = ALU_ADD;
                case (op_i)
                    OP_LW, OP_SW: state_next = ST_MEM_ADDR;
                    OP_R:         state_next = ST_R_EXEC;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_ADDI:      state_next = ST_I_EXEC;
                    OP_J:         state_next = ST_JUMP;
                    default:      state_next = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_next     = (op_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                if (mem_ready_i) state_next = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                retire          = 1'b1;
                state_next      = ST_FETCH;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                if (mem_ready_i) begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RT;
                ctrl.alu_op    = ALU_FUNCT;
                state_next     = ST_R_WB;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                retire         = 1'b1;
                state_next     = ST_FETCH;
            end
            ST_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_next     = ST_I_WB;
            end
            ST_I_WB: begin
                ctrl.reg_write = 1'b1;
                retire         = 1'b1;
                state_next     = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RT;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PC_SRC_ALUOUT;
                ctrl.pc_en     = zero_i;
                retire         = 1'b1;
                state_next     = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_source = PC_SRC_JUMP;
                ctrl.pc_en     = 1'b1;
                retire         = 1'b1;
                state_next     = ST_FETCH;
            end
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg   <= ST_FETCH;
            retired_reg <= '0;
            trap_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (retire) retired_reg <= retired_reg + {{(RETIRE_W-1){1'b0}}, 1'b1};
            if (state_next == ST_TRAP) trap_reg <= 1'b1;
        end
    end

    // Outputs are gated by the reset pin directly so an asserted reset drops
    // any pending memory request in the same cycle, not at the next edge.
    assign ctrl_gated   = rst_i ? ctrl : '0;

    assign pc_en_o      = ctrl_gated.pc_en;
    assign iord_o       = ctrl_gated.iord;
    assign mem_read_o   = ctrl_gated.mem_read;
    assign mem_write_o  = ctrl_gated.mem_write;
    assign ir_write_o   = ctrl_gated.ir_write;
    assign mem_to_reg_o = ctrl_gated.mem_to_reg;
    assign reg_dst_o    = ctrl_gated.reg_dst;
    assign reg_write_o  = ctrl_gated.reg_write;
    assign alu_src_a_o  = ctrl_gated.alu_src_a;
    assign alu_src_b_o  = ctrl_gated.alu_src_b;
    assign alu_op_o     = ctrl_gated.alu_op;
    assign pc_source_o  = ctrl_gated.pc_source;
    assign trap_o       = rst_i & trap_reg;
    assign retired_o    = retired_reg;

endmodule
